sp_ram: RTL and testbench
=========================

Name: sp_ram

Overview:
Single-port synchronous RAM with one shared address bus for reads and writes, and a registered read port. It is the memory macro used by compiled processor/stream blocks, which drive address, data and write enable directly and sample data_out. A built-in clear sequencer zeroes the whole array after reset, so contents are deterministic before first use.

Parameters:
address_width, 32, width of the address port in bits.
data_width, 32, width of the data_in and data_out words in bits.
depth, 256, number of words in the array; legal range 2..2^address_width, power of two not required.

Ports:
clk  input  1  clock; all state changes on its rising edge.
rst  input  1  synchronous active-high reset, sampled on the rising clk edge.
address  input  address_width  word address, shared by read and write.
data_in  input  data_width  write data.
write_enable  input  1  high on a rising edge writes data_in to address.
data_out  output  data_width  registered read data.
busy  output  1  high while the post-reset clear sweep runs; accesses are not serviced.

Behaviour:
- Reset: rst high at an edge sets data_out=0, busy=1 and the clear pointer to 0; array contents are not touched on that edge. Asserting rst mid-sweep restarts the sweep from 0.
- Clear sweep: the first edge with rst low writes 0 to word 0. Each following edge with rst low writes 0 to the next word, one word per cycle, through word depth-1.
- Sweep timing: busy falls on the same edge that clears word depth-1, so busy is high for exactly depth cycles after rst falls.
- During the sweep: write_enable is ignored and data_out is held at 0.
- Normal operation (busy=0, rst=0), each rising edge:
  - In range (address < depth) with write_enable=1: mem[address] <= data_in.
  - In range: data_out <= mem[address] as it was before this edge's write (read-first). A write cycle therefore outputs the old contents.
  - Out of range (address >= depth): the write is dropped and data_out <= 0. No wrap-around; upper address bits are never discarded.
- Read latency: one cycle. Address presented before edge N appears on data_out after edge N. data_out holds its value between edges.
- Back-to-back: a write at edge N followed by a read of the same address at edge N+1 returns the new data after edge N+1.
- Widths: data is stored and returned unmodified at data_width bits, with no sign extension. The address compares against depth as an unsigned value.
- Storage: inferable as block RAM. The clear sweep uses the normal write port, so no multi-port access is needed.

Test Plan:
- Reset/clear: preload mem[5]=0xDEADBEEF, pulse rst for 5 cycles, release -> busy=1 for exactly 256 cycles, data_out=0 throughout; afterwards reading address 5 gives 0x00000000 one cycle later.
- Write then read: after busy=0, write address i with value i*3+1 for i=0..255, then read 0..255 -> data_out equals i*3+1 one cycle after each address; mem[255]=766.
- Read-first: mem[10]=0x11111111; write 0x22222222 to address 10 -> data_out after that edge = 0x11111111; next cycle read address 10 -> 0x22222222.
- Out of range: write 0xCAFEF00D to address 256 and to 0xFFFFFFFF -> data_out=0; mem[0] unchanged, and reading 256 returns 0.
- Busy lockout and mid-sweep reset: assert write_enable with address 3 at clear cycle 10 -> mem[3] reads 0 afterwards. Reassert rst at sweep cycle 100 -> busy stays high for a further 256 cycles after release.
- Hold: keep address=7 constant with no writes for 20 cycles -> data_out is stable at mem[7] on every cycle.

Source files
------------

// File: rtl/sp_ram.sv
// Single-port synchronous RAM with read-first registered output and a post-reset
// clear sweep that zeroes every word through the normal write port.
module sp_ram #(
  parameter int unsigned address_width = 32,
  parameter int unsigned data_width    = 32,
  parameter int unsigned depth         = 256
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [address_width-1:0] address,
  input  logic [data_width-1:0]    data_in,
  input  logic                     write_enable,
  output logic [data_width-1:0]    data_out,
  output logic                     busy
);

  localparam int unsigned PtrW = (depth > 1) ? $clog2(depth) : 1;
  localparam logic [address_width:0] DepthExt = (address_width + 1)'(depth);
  localparam logic [PtrW-1:0] LastPtr = PtrW'(depth - 1);

  logic [data_width-1:0] mem [depth];

  logic [PtrW-1:0]       clr_ptr_d, clr_ptr_q;
  logic                  busy_d, busy_q;
  logic                  rd_valid_d, rd_valid_q;
  logic [data_width-1:0] rd_data_q;

  logic                  in_range;
  logic                  mem_we;
  logic [PtrW-1:0]       mem_addr;
  logic [data_width-1:0] mem_wdata;

  // Extra top bit lets depth == 2^address_width compare correctly.
  assign in_range = {1'b0, address} < DepthExt;

  always_comb begin
    clr_ptr_d  = clr_ptr_q;
    busy_d     = busy_q;
    rd_valid_d = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = address[PtrW-1:0];
    mem_wdata  = data_in;
    if (rst) begin
      clr_ptr_d = '0;
      busy_d    = 1'b1;
    end else if (busy_q) begin
      mem_we    = 1'b1;
      mem_addr  = clr_ptr_q;
      mem_wdata = '0;
      clr_ptr_d = clr_ptr_q + 1'b1;
      if (clr_ptr_q == LastPtr) begin
        busy_d = 1'b0;
      end
    end else begin
      mem_we     = write_enable & in_range;
      rd_valid_d = in_range;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      clr_ptr_q  <= '0;
      busy_q     <= 1'b1;
      rd_valid_q <= 1'b0;
    end else begin
      clr_ptr_q  <= clr_ptr_d;
      busy_q     <= busy_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  // Storage kept free of reset so it maps onto block RAM; read is old-data on write.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
    end
    rd_data_q <= mem[mem_addr];
  end

  assign data_out = rd_valid_q ? rd_data_q : '0;
  assign busy     = busy_q;

endmodule

// File: tb/tb_sp_ram.sv
// Directed bench for sp_ram: clear sweep, lockout, read-first, range checks, hold.
module tb_sp_ram;

  logic        clk;
  logic        rst;
  logic [31:0] address;
  logic [31:0] data_in;
  logic        write_enable;
  logic [31:0] data_out;
  logic        busy;

  int vectors;
  int miscompares;

  sp_ram #(
    .address_width(32),
    .data_width   (32),
    .depth        (256)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .address     (address),
    .data_in     (data_in),
    .write_enable(write_enable),
    .data_out    (data_out),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Runs a clear sweep from rst low; optionally pokes a write or re-asserts rst
  // for one edge. n counts edges since the last rst edge until busy drops.
  task automatic run_sweep(input int poke_at, input int rst_at, output int n,
                           output logic dz);
    n  = 0;
    dz = 1'b1;
    for (int c = 1; c <= 2000; c++) begin
      rst          = (c == rst_at);
      write_enable = (c == poke_at);
      address      = (c == poke_at) ? 32'd3 : 32'd0;
      data_in      = 32'hAAAA_5555;
      tick();
      if (data_out !== 32'h0) dz = 1'b0;
      if (rst) n = 0;
      else n++;
      if (!busy) break;
    end
    rst          = 1'b0;
    write_enable = 1'b0;
  endtask

  task automatic access(input logic [31:0] a, input logic we, input logic [31:0] d);
    address      = a;
    write_enable = we;
    data_in      = d;
    tick();
    write_enable = 1'b0;
  endtask

  initial begin
    int   n;
    logic dz;
    vectors      = 0;
    miscompares  = 0;
    rst          = 1'b1;
    address      = '0;
    data_in      = '0;
    write_enable = 1'b0;

    repeat (5) tick();
    check("reset_busy", {31'b0, busy}, 32'd1);
    check("reset_dout", data_out, 32'h0);

    // First sweep, with a write attempt to word 3 at clear cycle 10.
    run_sweep(10, 0, n, dz);
    check("sweep1_len", n, 32'd256);
    check("sweep1_dout_zero", {31'b0, dz}, 32'd1);
    access(32'd3, 1'b0, 32'h0);
    check("lockout_mem3", data_out, 32'h0);

    // Preload word 5, then reset and confirm it is cleared.
    access(32'd5, 1'b1, 32'hDEAD_BEEF);
    access(32'd5, 1'b0, 32'h0);
    check("preload_mem5", data_out, 32'hDEAD_BEEF);
    rst = 1'b1;
    repeat (5) tick();
    check("reset2_busy", {31'b0, busy}, 32'd1);
    run_sweep(0, 100, n, dz);
    check("sweep2_restart_len", n, 32'd256);
    check("sweep2_dout_zero", {31'b0, dz}, 32'd1);
    check("sweep2_busy_low", {31'b0, busy}, 32'd0);
    access(32'd5, 1'b0, 32'h0);
    check("cleared_mem5", data_out, 32'h0);

    // Fill and read back every word.
    for (int i = 0; i < 256; i++) access(i, 1'b1, i * 3 + 1);
    for (int i = 0; i < 256; i++) begin
      access(i, 1'b0, 32'h0);
      check($sformatf("fill_rd[%0d]", i), data_out, i * 3 + 1);
    end

    // Read-first on write cycles.
    access(32'd10, 1'b1, 32'h1111_1111);
    check("rf_old31", data_out, 32'd31);
    access(32'd10, 1'b1, 32'h2222_2222);
    check("rf_old", data_out, 32'h1111_1111);
    access(32'd10, 1'b0, 32'h0);
    check("rf_new", data_out, 32'h2222_2222);

    // Back-to-back write then read of a fresh address.
    access(32'd20, 1'b1, 32'h1234_5678);
    check("b2b_old", data_out, 32'd61);
    access(32'd20, 1'b0, 32'h0);
    check("b2b_new", data_out, 32'h1234_5678);

    // Out-of-range writes are dropped and read as zero.
    access(32'd255, 1'b0, 32'h0);
    check("oor_pre", data_out, 32'd766);
    access(32'd256, 1'b1, 32'hCAFE_F00D);
    check("oor_wr256", data_out, 32'h0);
    access(32'hFFFF_FFFF, 1'b1, 32'hCAFE_F00D);
    check("oor_wrmax", data_out, 32'h0);
    access(32'd0, 1'b0, 32'h0);
    check("oor_mem0", data_out, 32'd1);
    access(32'd256, 1'b0, 32'h0);
    check("oor_rd256", data_out, 32'h0);
    access(32'h0000_0100 | 32'h8000_0000, 1'b0, 32'h0);
    check("oor_nowrap", data_out, 32'h0);

    // Hold: constant address, no writes.
    address = 32'd7;
    for (int i = 0; i < 20; i++) begin
      tick();
      check($sformatf("hold[%0d]", i), data_out, 32'd22);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
